// File: rtl/rega_pkg.sv
// rega_pkg: state encoding and default timing constants for the irrigation
// scheduler (mef_agenda_rega). The fertilize/clean responder uses the same
// encoding, so keep the values stable.
package rega_pkg;

  // 3-bit state encoding of the scheduler FSM.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEB   = 3'd1,
    IRR   = 3'd2,
    WAIT  = 3'd3,
    COOL  = 3'd4,
    FAULT = 3'd5
  } state_t;

  // Default cycle counts. Each count must fit in DEF_CW bits and be >= 1.
  localparam int DEF_DEB_CYC  = 4;   // consecutive dry cycles before irrigating
  localparam int DEF_IRR_CYC  = 16;  // Asp high time in IRR
  localparam int DEF_COOL_CYC = 8;   // forced idle after a cycle
  localparam int DEF_TMO_CYC  = 64;  // responder stall limit in WAIT
  localparam int DEF_CW       = 8;   // counter width

endpackage

// File: rtl/mef_agenda_rega_if.sv
// mef_agenda_rega_if: sprinkle/fertilize handshake between the irrigation
// scheduler (master) and the fertilize/clean responder (slave).
//   Asp  master->slave  sprinkle enable
//   Adub master->slave  fertilize request, meaningful only with Asp
//   Ve   slave->master  tank refill valve open
//   Mist slave->master  mixing (fertilize) active
//   Limp slave->master  cleaning active
interface mef_agenda_rega_if;
  logic Asp;
  logic Adub;
  logic Ve;
  logic Mist;
  logic Limp;

  modport master (output Asp, Adub, input  Ve, Mist, Limp);
  modport slave  (input  Asp, Adub, output Ve, Mist, Limp);
endinterface

// File: rtl/sincroniza_borda.sv
// sincroniza_borda: 2-FF synchronizer for an asynchronous input, plus a
// rising-edge pulse derived from the synchronized value and its delayed copy.
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   d     in  asynchronous input
//   q     out synchronized level
//   rise  out one-cycle pulse when q goes 0->1
module sincroniza_borda (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      // NOTE: non-blocking so the three stages shift as a pipeline;
      // blocking here would collapse them into a single flop.
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~sync_d;

endmodule

// File: rtl/mef_agenda_rega.sv
// mef_agenda_rega: irrigation scheduler FSM, initiator of the sprinkle/
// fertilize handshake. Debounces the soil-dry sensor, drives Asp/Adub to the
// fertilize/clean responder and faults if the responder stalls too long.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   Seco   in  soil-dry sensor (async, 1 = dry)
//   AdubSw in  fertilize request pushbutton (async, 1 = pressed)
//   rsp    master side of the handshake (Asp, Adub out; Ve, Mist, Limp in)
//   Busy   out high in IRR, WAIT, COOL
//   Err    out sticky fault flag (left only through reset)
module mef_agenda_rega
  import rega_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int IRR_CYC  = DEF_IRR_CYC,
  parameter int COOL_CYC = DEF_COOL_CYC,
  parameter int TMO_CYC  = DEF_TMO_CYC,
  parameter int CW       = DEF_CW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Seco,
  input  logic               AdubSw,
  mef_agenda_rega_if.master  rsp,
  output logic               Busy,
  output logic               Err
);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] IRR_LAST  = CW'(IRR_CYC - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          seco_s;
  logic          seco_rise_unused;
  logic          adub_s;
  logic          adub_rise;
  logic          adub_lat;
  logic          adub_cur;
  logic          rsp_active;
  logic          to_irr;

  sincroniza_borda u_sync_seco (
    .clk   (clk),
    .reset (reset),
    .d     (Seco),
    .q     (seco_s),
    .rise  (seco_rise_unused)
  );

  sincroniza_borda u_sync_adub (
    .clk   (clk),
    .reset (reset),
    .d     (AdubSw),
    .q     (adub_s),
    .rise  (adub_rise)
  );

  assign rsp_active = rsp.Ve | rsp.Mist | rsp.Limp;
  assign to_irr     = (state == DEB) && (state_nxt == IRR);

  // State register and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and next-count logic. Every state leaves at its terminal
  // count, so cnt never wraps; cnt restarts at 0 on every transition.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (seco_s) begin
          state_nxt = DEB;
          cnt_nxt   = '0;
        end
      end
      DEB: begin
        if (!seco_s) begin
          // Dry reading lost: restart the debounce with no partial credit.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IRR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IRR: begin
        if (cnt == IRR_LAST) begin
          state_nxt = rsp_active ? WAIT : COOL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (!rsp_active) begin
          state_nxt = COOL;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nxt = FAULT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COOL: begin
        if (cnt == COOL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Fertilize request bookkeeping. adub_lat remembers a press until the next
  // irrigation starts; adub_cur is the value frozen for the running cycle, so
  // Adub cannot change while Asp is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adub_lat <= 1'b0;
      adub_cur <= 1'b0;
    end else begin
      // A press on the same edge as the copy wins, so it is not lost.
      if (adub_rise && (state != FAULT)) begin
        adub_lat <= 1'b1;
      end else if (to_irr) begin
        adub_lat <= 1'b0;
      end

      if (to_irr) begin
        adub_cur <= adub_lat;
      end else if (state == COOL) begin
        adub_cur <= 1'b0;
      end
    end
  end

  // Output decode: Moore, except Asp in WAIT follows ~Ve so the sprinkler
  // backs off while the responder refills its tank.
  always_comb begin
    rsp.Asp  = 1'b0;
    rsp.Adub = 1'b0;
    Busy     = 1'b0;
    Err      = 1'b0;
    unique case (state)
      IRR: begin
        rsp.Asp  = 1'b1;
        rsp.Adub = adub_cur;
        Busy     = 1'b1;
      end
      WAIT: begin
        rsp.Asp  = ~rsp.Ve;
        rsp.Adub = adub_cur;
        Busy     = 1'b1;
      end
      COOL: begin
        Busy = 1'b1;
      end
      FAULT: begin
        Err = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
